// File: rtl/cal_acc_pkg.sv
// Shared types and constants for the calibration bin accumulator.
// Build option: CAL_ACC_ROUND_EN selects round-half-up averaging (default truncates).
package cal_acc_pkg;

  localparam int NBINS     = 512;
  localparam int ACC_W     = 38;
  localparam int IN_W      = 32;
  localparam int MAX_SHIFT = 6;
  localparam int BIN_W     = 9;
  localparam int SHIFT_W   = 3;
  localparam int FRAME_W   = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One accepted sample travelling towards the RMW stage.
  typedef struct packed {
    logic             valid;
    logic [BIN_W-1:0] bin;
    logic             last;
    logic             first;
  } pipe_t;

  // Frame counts above 2^MAX_SHIFT are not supported; larger requests saturate.
  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
    return (s > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : s;
  endfunction

  // Index of the final frame of a run, 2^s - 1.
  function automatic logic [FRAME_W-1:0] last_frame_idx(input logic [SHIFT_W-1:0] s);
    logic [FRAME_W:0] n;
    n = ((FRAME_W+1)'(1) << s) - (FRAME_W+1)'(1);
    return n[FRAME_W-1:0];
  endfunction

endpackage

// File: rtl/cal_acc_ctrl.sv
// Run controller: IDLE/RUN state, expected-bin counter, frame counter and
// the sticky bin-sequence error flag.
// Build option CAL_ACC_ROUND_EN does not affect this block.
module cal_acc_ctrl
  import cal_acc_pkg::*;
#(
  parameter int NBINS = 512
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [SHIFT_W-1:0] avg_shift_i,
  input  logic               in_valid_i,
  input  logic [BIN_W-1:0]   in_bin_i,
  output logic               accept_o,
  output logic               first_o,
  output logic               last_o,
  output logic [SHIFT_W-1:0] shift_o,
  output logic               seq_err_o,
  output state_e             state_o
);

  // Input stream handshake: in_valid is a pure strobe with no ready; a sample
  // is consumed in the cycle it is presented, and only when the controller is
  // in RUN and in_bin equals the expected bin. Anything else is never retried.

  state_e             state_q;
  logic [BIN_W-1:0]   exp_bin_q;
  logic [FRAME_W-1:0] frame_q;
  logic [SHIFT_W-1:0] shift_q;
  logic               seq_err_q;

  logic in_run;
  logic bin_match;
  logic mismatch;
  logic bin_wrap;

  assign in_run    = (state_q == ST_RUN);
  assign bin_match = (in_bin_i == exp_bin_q);
  assign accept_o  = in_run && in_valid_i && bin_match;
  assign mismatch  = in_run && in_valid_i && !bin_match;
  assign bin_wrap  = (exp_bin_q == BIN_W'(NBINS - 1));
  assign first_o   = (frame_q == '0);
  assign last_o    = (frame_q == last_frame_idx(shift_q));

  assign shift_o   = shift_q;
  assign seq_err_o = seq_err_q;
  assign state_o   = state_q;

  // Run FSM with its counters; all outputs of this block that leave the
  // accelerator are taken straight from these registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      exp_bin_q <= '0;
      frame_q   <= '0;
      shift_q   <= '0;
      seq_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            shift_q   <= clamp_shift(avg_shift_i);
            frame_q   <= '0;
            exp_bin_q <= '0;
            seq_err_q <= 1'b0;
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (mismatch) begin
            seq_err_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (accept_o) begin
            if (bin_wrap) begin
              exp_bin_q <= '0;
              if (last_o) begin
                state_q <= ST_IDLE;
              end else begin
                frame_q <= frame_q + FRAME_W'(1);
              end
            end else begin
              exp_bin_q <= exp_bin_q + BIN_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cal_bin_accumulator.sv
// Per-bin frame averager driving a two-port calibration SRAM by
// read-modify-write. The SRAM itself lives outside this block.
// Build option: CAL_ACC_ROUND_EN -> round half up on the final shift;
// otherwise the average is a truncating arithmetic shift.
module cal_bin_accumulator
  import cal_acc_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int NBINS      = 512
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [SHIFT_W-1:0] avg_shift,
  input  logic               in_valid,
  input  logic [BIN_W-1:0]   in_bin,
  input  logic [IN_W-1:0]    in_data,
  output logic               out_valid,
  output logic [BIN_W-1:0]   out_bin,
  output logic [IN_W-1:0]    out_data,
  output logic               busy,
  output logic               seq_err,
  output logic [BIN_W-1:0]   ram_raddr,
  input  logic [ACC_W-1:0]   ram_rdata,
  output logic [BIN_W-1:0]   ram_waddr,
  output logic [ACC_W-1:0]   ram_wdata,
  output logic               ram_wen
);

  logic               ctrl_accept;
  logic               ctrl_first;
  logic               ctrl_last;
  logic [SHIFT_W-1:0] ctrl_shift;
  state_e             ctrl_state;

  cal_acc_ctrl #(
    .NBINS (NBINS)
  ) u_ctrl (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .start_i     (start),
    .avg_shift_i (avg_shift),
    .in_valid_i  (in_valid),
    .in_bin_i    (in_bin),
    .accept_o    (ctrl_accept),
    .first_o     (ctrl_first),
    .last_o      (ctrl_last),
    .shift_o     (ctrl_shift),
    .seq_err_o   (seq_err),
    .state_o     (ctrl_state)
  );

  assign busy = (ctrl_state == ST_RUN);

  // The read is issued in the acceptance cycle so the old sum arrives exactly
  // when the sample reaches the end of the delay line.
  assign ram_raddr = in_bin;

  pipe_t stage_in;
  assign stage_in = '{valid: ctrl_accept, bin: in_bin, last: ctrl_last, first: ctrl_first};

  pipe_t              pipe_q  [RD_LATENCY];
  logic [IN_W-1:0]    data_q  [RD_LATENCY];
  logic [SHIFT_W-1:0] shift_q [RD_LATENCY];

  // Control side of the delay line; reset flushes any in-flight samples.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= stage_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Data side of the delay line; shift travels with the sample so a new run
  // started right behind an old one cannot change the old run's averaging.
  always_ff @(posedge CLK) begin
    data_q[0]  <= in_data;
    shift_q[0] <= ctrl_shift;
    for (int i = 1; i < RD_LATENCY; i++) begin
      data_q[i]  <= data_q[i-1];
      shift_q[i] <= shift_q[i-1];
    end
  end

  pipe_t              st;
  logic [IN_W-1:0]    st_data;
  logic [SHIFT_W-1:0] st_shift;

  assign st       = pipe_q[RD_LATENCY-1];
  assign st_data  = data_q[RD_LATENCY-1];
  assign st_shift = shift_q[RD_LATENCY-1];

  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;
`ifdef CAL_ACC_ROUND_EN
  logic        [ACC_W-1:0] round_add;
`endif

  // Accumulate (frame 0 ignores stale SRAM content) and form the average.
  always_comb begin
    in_ext = {{(ACC_W-IN_W){st_data[IN_W-1]}}, st_data};
    sum    = st.first ? in_ext : ($signed(ram_rdata) + in_ext);
`ifdef CAL_ACC_ROUND_EN
    round_add = '0;
    if (st_shift != '0) begin
      round_add = ACC_W'(1) << (st_shift - SHIFT_W'(1));
    end
    biased = sum + $signed(round_add);
`else
    biased = sum;
`endif
    shifted = biased >>> st_shift;
  end

  logic               ram_wen_q;
  logic [BIN_W-1:0]   ram_waddr_q;
  logic [ACC_W-1:0]   ram_wdata_q;
  logic               out_valid_q;
  logic [BIN_W-1:0]   out_bin_q;
  logic [IN_W-1:0]    out_data_q;
  logic [IN_W-1:0]    out_data_d;

  assign out_data_d = IN_W'(shifted);

  // Registered write-back for intermediate frames, result strobe for the last.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ram_wen_q   <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_data_q  <= '0;
    end else begin
      ram_wen_q   <= st.valid && !st.last;
      out_valid_q <= st.valid && st.last;
      if (st.valid && !st.last) begin
        ram_waddr_q <= st.bin;
        ram_wdata_q <= sum;
      end
      if (st.valid && st.last) begin
        out_bin_q  <= st.bin;
        out_data_q <= out_data_d;
      end
    end
  end

  assign ram_wen   = ram_wen_q;
  assign ram_waddr = ram_waddr_q;
  assign ram_wdata = ram_wdata_q;
  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_cal_bin_accumulator.sv
// Bench for cal_bin_accumulator with a behavioural SRAM and an arithmetic
// reference model of per-bin frame averaging.
module tb_cal_bin_accumulator;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [2:0]  avg_shift;
  logic        in_valid;
  logic [8:0]  in_bin;
  logic [31:0] in_data;
  logic        out_valid;
  logic [8:0]  out_bin;
  logic [31:0] out_data;
  logic        busy;
  logic        seq_err;
  logic [8:0]  ram_raddr;
  logic [37:0] ram_rdata;
  logic [8:0]  ram_waddr;
  logic [37:0] ram_wdata;
  logic        ram_wen;

  // ---------------- clock / reset block ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  cal_bin_accumulator #(.RD_LATENCY(2), .NBINS(512)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start),
    .avg_shift (avg_shift),
    .in_valid  (in_valid),
    .in_bin    (in_bin),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_data  (out_data),
    .busy      (busy),
    .seq_err   (seq_err),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_wen   (ram_wen)
  );

  // Two-port SRAM, read latency 2 (array read plus output register).
  logic [37:0] mem [512];
  logic [37:0] rd_p1;
  always @(posedge CLK) begin
    rd_p1     <= mem[ram_raddr];
    ram_rdata <= rd_p1;
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [40:0] exp_q[$];
  int          exp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  int          wen_cnt = 0;
  int          out_cnt = 0;
  int          tbl_ok = 0;
  bit          tbl_on = 0;
  logic [31:0] tbl_base = '0;
  logic [31:0] tbl_bstep = '0;

  always @(negedge CLK) begin
    logic [40:0] e;
    int          ec;
    if (ram_wen === 1'b1) wen_cnt++;
    if (out_valid === 1'b1) begin
      out_cnt++;
      if (tbl_on && out_data == tbl_base + 32'(out_bin) * tbl_bstep) tbl_ok++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out bin=%0d data=%0h required=no_output", out_bin, out_data);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("out_cyc_bin_data", {16'(cyc), 7'd0, out_bin, out_data}, {16'(ec), 7'd0, e});
      end
    end
  end

  // ---------------- reference model ----------------
  bit     m_run = 0;
  int     m_bin = 0;
  int     m_frame = 0;
  int     m_s = 0;
  longint acc [512];

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_sample(input int bin, input logic [31:0] data);
    longint x, d, r;
    if (!m_run) return;
    if (bin != m_bin) begin
      m_run = 0;
      return;
    end
    x = longint'($signed(data));
    acc[bin] = (m_frame == 0) ? x : acc[bin] + x;
    if (m_frame == (1 << m_s) - 1) begin
      d = longint'(1) << m_s;
`ifdef CAL_ACC_ROUND_EN
      r = floor_div(acc[bin] + d / 2, d);
`else
      r = floor_div(acc[bin], d);
`endif
      exp_q.push_back({9'(bin), 32'(r)});
      exp_cyc_q.push_back(cyc + 3);
    end
    m_bin++;
    if (m_bin == 512) begin
      m_bin = 0;
      if (m_frame == (1 << m_s) - 1) m_run = 0;
      else m_frame++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input int bin, input logic [31:0] data);
    in_valid = 1'b1;
    in_bin   = 9'(bin);
    in_data  = data;
    model_sample(bin, data);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_start(input int s);
    start     = 1'b1;
    avg_shift = 3'(s);
    if (!m_run) begin
      m_run   = 1;
      m_s     = (s > 6) ? 6 : s;
      m_frame = 0;
      m_bin   = 0;
    end
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    m_run = 0;
    while (exp_cyc_q.size() > 0 && exp_cyc_q[$] > cyc) begin
      void'(exp_q.pop_back());
      void'(exp_cyc_q.pop_back());
    end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic drain();
    idle(6);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct {
    int          shift;
    int          base;
    int          step;
    int          bstep;
    logic [31:0] exp_base;
    logic [31:0] exp_bstep;
    int          exp_wen;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int   w0, o0, nf, s;
    logic [31:0] rnd_round;

`ifdef CAL_ACC_ROUND_EN
    rnd_round = 32'hFFFF_FFFD;  // -7/2 rounds half up to -3
`else
    rnd_round = 32'hFFFF_FFFC;  // -7/2 truncates to -4
`endif
    tbl[0] = '{2, 100, 100, 0, 32'd250, 32'd0, 1536};
    tbl[1] = '{0, 0, 0, 1, 32'd0, 32'd1, 0};
    tbl[2] = '{1, -3, -1, 0, rnd_round, 32'd0, 512};
    tbl[3] = '{7, int'(32'h7FFF_FFFF), 0, 0, 32'h7FFF_FFFF, 32'd0, 63 * 512};
    tbl[4] = '{6, int'(32'h8000_0000), 0, 0, 32'h8000_0000, 32'd0, 63 * 512};

    RESET = 1'b1; start = 1'b0; avg_shift = '0;
    in_valid = 1'b0; in_bin = '0; in_data = '0;
    idle(3);
    RESET = 1'b0;
    idle(1);

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_bin",   64'(out_bin),   64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_seq_err",   64'(seq_err),   64'd0);
    check("rst_ram_wen",   64'(ram_wen),   64'd0);
    check("rst_ram_waddr", 64'(ram_waddr), 64'd0);
    check("rst_ram_wdata", 64'(ram_wdata), 64'd0);

    // samples while idle must be ignored
    send(0, 32'd5);
    send(1, 32'd6);
    drain();

    // table-driven full runs
    for (int i = 0; i < 5; i++) begin
      nf = 1 << ((tbl[i].shift > 6) ? 6 : tbl[i].shift);
      do_start(tbl[i].shift);
      check("busy_in_run", 64'(busy), 64'd1);
      w0 = wen_cnt; out_cnt = 0; tbl_ok = 0;
      tbl_base = tbl[i].exp_base; tbl_bstep = tbl[i].exp_bstep; tbl_on = 1;
      for (int f = 0; f < nf; f++)
        for (int b = 0; b < 512; b++)
          send(b, 32'(tbl[i].base + f * tbl[i].step + b * tbl[i].bstep));
      check("busy_after_last", 64'(busy), 64'd0);
      drain();
      tbl_on = 0;
      check("tbl_out_count", 64'(out_cnt), 64'd512);
      check("tbl_out_value", 64'(tbl_ok), 64'd512);
      check("tbl_wen_count", 64'(wen_cnt - w0), 64'(tbl[i].exp_wen));
    end

    // bin sequence error
    w0 = wen_cnt;
    do_start(1);
    for (int b = 0; b < 6; b++) send(b, $urandom);
    send(7, $urandom);
    idle(2);
    check("seq_err_set", 64'(seq_err), 64'd1);
    check("seq_err_busy", 64'(busy), 64'd0);
    send(6, $urandom);
    send(7, $urandom);
    drain();
    check("seq_err_wen", 64'(wen_cnt - w0), 64'd6);
    do_start(2);
    check("seq_err_cleared", 64'(seq_err), 64'd0);
    apply_reset();

    // reset in the middle of frame 1
    do_start(1);
    for (int b = 0; b < 512; b++) send(b, $urandom);
    for (int b = 0; b < 100; b++) send(b, $urandom);
    apply_reset();
    w0 = wen_cnt; o0 = out_cnt;
    idle(10);
    check("post_rst_wen", 64'(wen_cnt - w0), 64'd0);
    check("post_rst_out", 64'(out_cnt - o0), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    do_start(0);
    for (int b = 0; b < 512; b++) send(b, $urandom);
    drain();

    // randomized runs with gaps
    for (int r = 0; r < 3; r++) begin
      s = $urandom_range(0, 2);
      do_start(s);
      for (int f = 0; f < (1 << s); f++)
        for (int b = 0; b < 512; b++) begin
          if ($urandom_range(0, 7) == 0) idle(1);
          send(b, $urandom);
        end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
